avl_slave_sram: RTL and testbench



---
 rtl/avl_slave_sram_pkg.sv | 31 +++
 rtl/avl_slave_sram_be.sv | 40 ++++
 rtl/avl_slave_sram.sv | 174 +++++++++++++++++
 tb/tb_avl_slave_sram.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_slave_sram_pkg.sv
// ---------------------------------------------------------------------------
// avl_slave_sram_pkg
// Shared types and helpers for the Avalon-MM SRAM slave:
//   avl_slave_state_t  - slave command FSM states
//   avl_addr_hit()     - block decode: address lies in the 2**field_len block at base
//   avl_eff_count()    - effective burst length (0 -> 1, clamp to max_burst)
// ---------------------------------------------------------------------------
package avl_slave_sram_pkg;

   typedef enum logic [1:0] {
      AVL_SLV_IDLE,
      AVL_SLV_WR_BURST,
      AVL_SLV_RD_BURST
   } avl_slave_state_t;

   function automatic logic avl_addr_hit(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned field_len);
      return (addr >> field_len) == (base >> field_len);
   endfunction

   function automatic logic [7:0] avl_eff_count(input logic [7:0] burst_count,
                                                input int unsigned max_burst);
      if (burst_count == 8'd0)
         return 8'd1;
      if (32'(burst_count) > max_burst)
         return 8'(max_burst);
      return burst_count;
   endfunction

endpackage

// File: rtl/avl_slave_sram_be.sv
// ---------------------------------------------------------------------------
// avl_sram_be
// Single-port synchronous RAM, DEPTH x 32, per-byte write enables,
// registered read data (1-cycle latency, holds when re=0). Contents not reset.
// Ports:
//   clk      in   clock
//   addr     in   word address
//   we       in   write strobe (gated per lane by be)
//   be       in   byte-lane enables
//   wdata    in   write data
//   re       in   read strobe
//   rdata_q  out  read data, valid the cycle after re
// ---------------------------------------------------------------------------
module avl_sram_be #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = 12
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   input  logic          re,
   output logic [31:0]   rdata_q
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re)
         rdata_q <= mem[addr];
   end

endmodule

// File: rtl/avl_slave_sram.sv
// ---------------------------------------------------------------------------
// avl_slave_sram
// Avalon-MM slave backed by a word-organised sync SRAM. Supports single and
// burst reads/writes with fixed 1-cycle read latency.
// Ports:
//   clk, rest_n                 clock, async active-low reset
//   avl_address                 byte address (bits [1:0] ignored)
//   avl_byte_en                 write byte lanes
//   avl_read / avl_write        command strobes (write wins if both)
//   avl_write_data              write data
//   avl_begin_burst_transfer    burst start marker (informational only)
//   avl_burst_count             beats in burst (0 -> 1, clamped to MAX_BURST)
//   avl_wait_request            high while a read burst is being issued
//   avl_read_data               read data, holds when not valid
//   avl_read_data_valid         read data valid
// ---------------------------------------------------------------------------
module avl_slave_sram
   import avl_slave_sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned FIELD_LEN = 16,
   parameter int unsigned DEPTH     = 4096,
   parameter int unsigned MAX_BURST = 128
) (
   input  logic        clk,
   input  logic        rest_n,
   input  logic [31:0] avl_address,
   input  logic [3:0]  avl_byte_en,
   input  logic        avl_read,
   input  logic        avl_write,
   input  logic [31:0] avl_write_data,
   input  logic        avl_begin_burst_transfer,
   input  logic [7:0]  avl_burst_count,
   output logic        avl_wait_request,
   output logic [31:0] avl_read_data,
   output logic        avl_read_data_valid
);

   localparam int unsigned IW = FIELD_LEN - 2;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   avl_slave_state_t state_q, state_d;
   logic [7:0]       rem_q, rem_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             hit_q, hit_d;
   logic             vld_q, vld_d;
   logic             oor_q, oor_d;

   logic [31:0]      offset;
   logic [IW-1:0]    cmd_idx;
   logic             cmd_hit;
   logic [7:0]       cmd_cnt;
   logic [IW-1:0]    acc_idx;
   logic             acc_ok;
   logic             ram_we;
   logic             ram_re;
   logic [31:0]      ram_rdata;
   logic             unused_ok;

   function automatic logic in_range(input logic [IW-1:0] idx, input logic hit);
      return hit && (32'(idx) < DEPTH);
   endfunction

   // Burst address advance wraps at the implemented depth, not the block size.
   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
      return (32'(idx) == DEPTH - 1) ? '0 : idx + 1'b1;
   endfunction

   assign offset  = avl_address - BASE_ADDR;
   assign cmd_idx = offset[FIELD_LEN-1:2];
   assign cmd_hit = avl_addr_hit(avl_address, BASE_ADDR, FIELD_LEN);
   assign cmd_cnt = avl_eff_count(avl_burst_count, MAX_BURST);

   // Next state and per-beat RAM access. An address outside the block is
   // handled like an out-of-range word so the master always gets a response.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      idx_d   = idx_q;
      hit_d   = hit_q;
      vld_d   = 1'b0;
      oor_d   = oor_q;
      acc_idx = idx_q;
      acc_ok  = in_range(idx_q, hit_q);
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      case (state_q)
         AVL_SLV_IDLE: begin
            acc_idx = cmd_idx;
            acc_ok  = in_range(cmd_idx, cmd_hit);
            if (avl_write) begin
               ram_we = acc_ok;
               if (cmd_cnt > 8'd1) begin
                  state_d = AVL_SLV_WR_BURST;
                  rem_d   = cmd_cnt - 8'd1;
                  idx_d   = next_idx(cmd_idx);
                  hit_d   = cmd_hit;
               end
            end else if (avl_read) begin
               ram_re = acc_ok;
               vld_d  = 1'b1;
               oor_d  = !acc_ok;
               if (cmd_cnt > 8'd1) begin
                  state_d = AVL_SLV_RD_BURST;
                  rem_d   = cmd_cnt - 8'd1;
                  idx_d   = next_idx(cmd_idx);
                  hit_d   = cmd_hit;
               end
            end
         end
         AVL_SLV_WR_BURST: begin
            if (avl_write) begin
               ram_we = acc_ok;
               rem_d  = rem_q - 8'd1;
               idx_d  = next_idx(idx_q);
               if (rem_q == 8'd1)
                  state_d = AVL_SLV_IDLE;
            end
         end
         AVL_SLV_RD_BURST: begin
            ram_re = acc_ok;
            vld_d  = 1'b1;
            oor_d  = !acc_ok;
            rem_d  = rem_q - 8'd1;
            idx_d  = next_idx(idx_q);
            if (rem_q == 8'd1)
               state_d = AVL_SLV_IDLE;
         end
         default: state_d = AVL_SLV_IDLE;
      endcase
   end

   // oor_q resets to 1 so read_data shows 0 out of reset while the RAM
   // output register is still undefined.
   always_ff @(posedge clk or negedge rest_n) begin
      if (!rest_n) begin
         state_q <= AVL_SLV_IDLE;
         rem_q   <= '0;
         idx_q   <= '0;
         hit_q   <= 1'b0;
         vld_q   <= 1'b0;
         oor_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         hit_q   <= hit_d;
         vld_q   <= vld_d;
         oor_q   <= oor_d;
      end
   end

   always_comb begin
      avl_wait_request    = (state_q == AVL_SLV_RD_BURST);
      avl_read_data_valid = vld_q;
      avl_read_data       = oor_q ? 32'h0 : ram_rdata;
   end

   avl_sram_be #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .addr    (acc_idx[AW-1:0]),
      .we      (ram_we),
      .be      (avl_byte_en),
      .wdata   (avl_write_data),
      .re      (ram_re),
      .rdata_q (ram_rdata)
   );

   assign unused_ok = ^{avl_begin_burst_transfer, offset, acc_idx};

endmodule

// File: tb/tb_avl_slave_sram.sv
module tb_avl_slave_sram;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          FL    = 12;
   localparam int          DEPTH = 256;
   localparam int          MAXB  = 128;

   logic        clk = 1'b0;
   logic        rest_n = 1'b0;
   logic [31:0] avl_address = '0;
   logic [3:0]  avl_byte_en = '0;
   logic        avl_read = 1'b0;
   logic        avl_write = 1'b0;
   logic [31:0] avl_write_data = '0;
   logic        avl_begin_burst_transfer = 1'b0;
   logic [7:0]  avl_burst_count = '0;
   logic        avl_wait_request;
   logic [31:0] avl_read_data;
   logic        avl_read_data_valid;

   avl_slave_sram #(
      .BASE_ADDR (BASE),
      .FIELD_LEN (FL),
      .DEPTH     (DEPTH),
      .MAX_BURST (MAXB)
   ) dut (
      .clk                      (clk),
      .rest_n                   (rest_n),
      .avl_address              (avl_address),
      .avl_byte_en              (avl_byte_en),
      .avl_read                 (avl_read),
      .avl_write                (avl_write),
      .avl_write_data           (avl_write_data),
      .avl_begin_burst_transfer (avl_begin_burst_transfer),
      .avl_burst_count          (avl_burst_count),
      .avl_wait_request         (avl_wait_request),
      .avl_read_data            (avl_read_data),
      .avl_read_data_valid      (avl_read_data_valid)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   // Reference memory: plain word array indexed by word offset.
   logic [31:0] mem_m [DEPTH];
   logic [31:0] wdat [MAXB];
   logic [3:0]  wbe  [MAXB];

   function automatic int eff(input int bc);
      if (bc == 0) return 1;
      if (bc > MAXB) return MAXB;
      return bc;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Scoreboard monitor: every valid beat must match the next expected word
   // in both data and arrival cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rest_n && avl_read_data_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_unexpected: got valid data %h, expected none", avl_read_data);
         end else begin
            e = sb.pop_front();
            check("rd_data", avl_read_data, e.data);
            check("rd_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic idle_bus();
      avl_read = 1'b0;
      avl_write = 1'b0;
      avl_begin_burst_transfer = 1'b0;
      avl_byte_en = 4'h0;
   endtask

   task automatic wr_burst(input logic [31:0] addr, input int bc, input int gap_after,
                           input logic also_read);
      int n;
      int woff;
      int idx;
      n = eff(bc);
      woff = int'((addr - BASE) >> 2);
      for (int k = 0; k < n; k++) begin
         avl_write = 1'b1;
         avl_read = also_read && (k == 0);
         avl_address = addr;
         avl_write_data = wdat[k];
         avl_byte_en = wbe[k];
         avl_burst_count = 8'(bc);
         avl_begin_burst_transfer = (k == 0);
         check("wr_wait", 32'(avl_wait_request), 32'h0);
         if (woff < DEPTH) begin
            idx = (woff + k) % DEPTH;
            for (int l = 0; l < 4; l++)
               if (wbe[k][l]) mem_m[idx][8*l +: 8] = wdat[k][8*l +: 8];
         end
         @(posedge clk); #1;
         if (k == gap_after) begin
            idle_bus();
            @(posedge clk); #1;
         end
      end
      idle_bus();
   endtask

   task automatic rd_burst(input logic [31:0] addr, input int bc);
      int n;
      int woff;
      exp_t e;
      n = eff(bc);
      woff = int'((addr - BASE) >> 2);
      avl_read = 1'b1;
      avl_address = addr;
      avl_burst_count = 8'(bc);
      avl_begin_burst_transfer = 1'b1;
      check("rd_accept_wait", 32'(avl_wait_request), 32'h0);
      for (int k = 0; k < n; k++) begin
         e.data = (woff >= DEPTH) ? 32'h0 : mem_m[(woff + k) % DEPTH];
         e.due  = cyc + 1 + k;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      idle_bus();
      for (int k = 1; k < n; k++) begin
         check("rd_wait_hi", 32'(avl_wait_request), 32'h1);
         @(posedge clk); #1;
      end
      check("rd_wait_lo", 32'(avl_wait_request), 32'h0);
   endtask

   task automatic set_single(input logic [31:0] d, input logic [3:0] b);
      wdat[0] = d;
      wbe[0] = b;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      int op, start, bc, n;
      logic [31:0] a;

      repeat (3) @(posedge clk);
      #1;
      check("rst_wait", 32'(avl_wait_request), 32'h0);
      check("rst_valid", 32'(avl_read_data_valid), 32'h0);
      check("rst_data", avl_read_data, 32'h0);
      rest_n = 1'b1;
      @(posedge clk); #1;

      // Fill the whole RAM with two maximum bursts.
      for (int h = 0; h < 2; h++) begin
         for (int k = 0; k < MAXB; k++) begin
            wdat[k] = $urandom;
            wbe[k] = 4'hF;
         end
         wr_burst(BASE + 32'(h * MAXB * 4), MAXB, -1, 1'b0);
      end

      // Single write then single read.
      set_single(32'h11223344, 4'hF);
      wr_burst(32'h8000_0010, 1, -1, 1'b0);
      rd_burst(32'h8000_0010, 1);

      // 4-beat write with a gap after the second beat, then 4-beat read.
      for (int k = 0; k < 4; k++) begin
         wdat[k] = 32'(k + 1);
         wbe[k] = 4'hF;
      end
      wr_burst(32'h8000_0100, 4, 1, 1'b0);
      rd_burst(32'h8000_0100, 4);

      // Byte-lane merge.
      set_single(32'hFFFF_FFFF, 4'hF);
      wr_burst(32'h8000_0080, 1, -1, 1'b0);
      set_single(32'h0000_00AB, 4'b0001);
      wr_burst(32'h8000_0080, 1, -1, 1'b0);
      rd_burst(32'h8000_0080, 1);
      check("be_merge_model", mem_m[32], 32'hFFFF_FFAB);
      set_single(32'h5555_5555, 4'h0);
      wr_burst(32'h8000_0080, 1, -1, 1'b0);
      rd_burst(32'h8000_0080, 1);

      // Out-of-range read and dropped write.
      rd_burst(BASE + DEPTH * 4, 1);
      set_single(32'hDEAD_BEEF, 4'hF);
      wr_burst(BASE + DEPTH * 4, 1, -1, 1'b0);
      rd_burst(BASE, 1);

      // Read and write together: write wins.
      set_single(32'hCAFE_0001, 4'hF);
      wr_burst(32'h8000_0040, 1, -1, 1'b1);
      rd_burst(32'h8000_0040, 1);

      // burst_count=0 and wrap at DEPTH-1.
      rd_burst(BASE + 32'h8, 0);
      rd_burst(BASE + (DEPTH - 1) * 4, 3);

      // Reset during an 8-beat read burst.
      avl_read = 1'b1;
      avl_address = BASE + 32'h20;
      avl_burst_count = 8'd8;
      avl_begin_burst_transfer = 1'b1;
      e.data = mem_m[8];
      e.due = cyc + 1;
      sb.push_back(e);
      @(posedge clk); #1;
      idle_bus();
      @(posedge clk); #1;
      rest_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(avl_read_data_valid), 32'h0);
      check("mid_rst_wait", 32'(avl_wait_request), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rest_n = 1'b1;
      check("mid_rst_sb", 32'(sb.size()), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_noextra", 32'(sb.size()), 32'h0);
      rd_burst(BASE + 32'h24, 1);

      // Randomized traffic.
      for (int t = 0; t < 60; t++) begin
         op = $urandom_range(0, 9);
         start = $urandom_range(0, DEPTH - 1);
         a = BASE + 32'(start * 4) + 32'($urandom_range(0, 3));
         bc = $urandom_range(0, 12);
         if (op <= 3) begin
            n = eff(bc);
            for (int k = 0; k < n; k++) begin
               wdat[k] = $urandom;
               wbe[k] = 4'($urandom_range(0, 15));
            end
            wr_burst(a, bc, $urandom_range(0, n) - 1, 1'b0);
         end else if (op <= 7) begin
            rd_burst(a, bc);
         end else if (op == 8) begin
            rd_burst(BASE + 32'($urandom_range(DEPTH, 1023) * 4), 1);
         end else begin
            rd_burst(a, $urandom_range(MAXB + 1, 255));
         end
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (4) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
